// File: rtl/panel_cmd_sequencer.sv
// ============================================================================
// panel_cmd_sequencer
//   Front-panel key debounce, toggle latches and prioritized console commands.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module panel_cmd_sequencer #(
    parameter int DEB_COUNT   = 4,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_tick,
    input  logic [8:0] key_raw,
    input  logic       cpu_run,
    input  logic       cmd_ack,
    output logic       single_step,
    output logic       halt,
    output logic       sw,
    output logic [5:0] cmd,
    output logic       cmd_valid,
    output logic       cmd_err,
    output logic       busy
);

    localparam logic [3:0]  C_DEB_LAST = 4'(DEB_COUNT - 1);
    localparam logic [15:0] C_ACK_LOAD = 16'(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_REL = 2'd2
    } state_t;

    logic [8:0]  deb;
    logic [8:0]  deb_prev_q;
    logic [8:0]  press;
    logic [5:0]  pend_q;
    logic [5:0]  pick;
    logic [5:0]  take;
    logic [5:0]  sel_q;
    logic [15:0] tmr_q;
    state_t      state_q;

    for (genvar gi = 0; gi < 9; gi++) begin : g_deb
        logic       deb_q;
        logic [3:0] cnt_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                deb_q <= 1'b0;
                cnt_q <= 4'd0;
            end else if (scan_tick) begin
                if (key_raw[gi] == deb_q) begin
                    cnt_q <= 4'd0;
                end else if (cnt_q == C_DEB_LAST) begin
                    deb_q <= key_raw[gi];
                    cnt_q <= 4'd0;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
            end
        end

        assign deb[gi] = deb_q;
    end

    // Edge detect on the debounced state gives one-clk press events.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_prev_q <= '0;
        end else begin
            deb_prev_q <= deb;
        end
    end

    assign press = deb & ~deb_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            single_step <= 1'b0;
            halt        <= 1'b0;
            sw          <= 1'b0;
        end else begin
            single_step <= single_step ^ press[6];
            halt        <= halt ^ press[7];
            sw          <= sw ^ press[8];
        end
    end

    // Priority: clear, addr_load, extd_addr, dep, exam, cont.
    always_comb begin
        pick = 6'd0;
        if (pend_q[2])      pick = 6'b000100;
        else if (pend_q[0]) pick = 6'b000001;
        else if (pend_q[1]) pick = 6'b000010;
        else if (pend_q[5]) pick = 6'b100000;
        else if (pend_q[4]) pick = 6'b010000;
        else if (pend_q[3]) pick = 6'b001000;
    end

    assign take = (state_q == ST_IDLE) ? pick : 6'd0;
    assign busy = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pend_q    <= '0;
            sel_q     <= '0;
            tmr_q     <= '0;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            pend_q  <= (pend_q & ~take) | (press[5:0] & {6{~cpu_run}});
            case (state_q)
                ST_IDLE: begin
                    if (|pend_q) begin
                        sel_q     <= pick;
                        cmd       <= pick;
                        cmd_valid <= 1'b1;
                        tmr_q     <= C_ACK_LOAD;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ack || (tmr_q == 16'd0)) begin
                        cmd       <= '0;
                        cmd_valid <= 1'b0;
                        state_q   <= ST_WAIT_REL;
                    end else begin
                        tmr_q <= tmr_q - 16'd1;
                        // Error pulse lines up with the final ISSUE cycle.
                        if (tmr_q == 16'd1) begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                ST_WAIT_REL: begin
                    if ((deb[5:0] & sel_q) == 6'd0) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_panel_cmd_sequencer.sv
// ============================================================================
// tb_panel_cmd_sequencer
//   Scenario tasks plus a randomized toggle-key run against a behavioural model.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_panel_cmd_sequencer;

    localparam int DEB = 4;
    localparam int TO  = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       scan_tick;
    logic [8:0] key_raw;
    logic       cpu_run;
    logic       cmd_ack;
    logic       single_step;
    logic       halt;
    logic       sw;
    logic [5:0] cmd;
    logic       cmd_valid;
    logic       cmd_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int vrise    = 0;
    logic vprev  = 1'b0;

    panel_cmd_sequencer #(
        .DEB_COUNT   (DEB),
        .ACK_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .scan_tick   (scan_tick),
        .key_raw     (key_raw),
        .cpu_run     (cpu_run),
        .cmd_ack     (cmd_ack),
        .single_step (single_step),
        .halt        (halt),
        .sw          (sw),
        .cmd         (cmd),
        .cmd_valid   (cmd_valid),
        .cmd_err     (cmd_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Counts commands presented (rising edges of cmd_valid).
    always @(posedge clk) begin
        vprev <= cmd_valid;
        if (cmd_valid && !vprev) vrise <= vrise + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic [8:0] kr);
        key_raw   = kr;
        scan_tick = 1'b1;
        step();
        scan_tick = 1'b0;
        step();
    endtask

    task automatic wait_valid(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cmd_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; scan_tick = 1'b0; key_raw = '0; cpu_run = 1'b0; cmd_ack = 1'b0;
        step(); step();
        checks++;
        if ({single_step, halt, sw, cmd, cmd_valid, cmd_err, busy} !== 12'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 0",
                     {single_step, halt, sw, cmd, cmd_valid, cmd_err, busy});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_debounce_toggle();
        for (int i = 0; i < DEB - 1; i++) tick(9'h080);
        for (int i = 0; i < DEB; i++) tick(9'h000);
        checks++;
        if (halt !== 1'b0) begin failures++; $display("FAIL halt_short_press: got %b expected 0", halt); end
        for (int i = 0; i < DEB - 1; i++) tick(9'h080);
        key_raw = 9'h080; scan_tick = 1'b1; step(); scan_tick = 1'b0;
        checks++;
        if (halt !== 1'b0) begin failures++; $display("FAIL halt_latency: got %b expected 0", halt); end
        step();
        checks++;
        if (halt !== 1'b1) begin failures++; $display("FAIL halt_set: got %b expected 1", halt); end
        for (int i = 0; i < DEB; i++) tick(9'h000);
        checks++;
        if (halt !== 1'b1) begin failures++; $display("FAIL halt_release: got %b expected 1", halt); end
        for (int i = 0; i < DEB + int'($urandom_range(0, 3)); i++) tick(9'h080);
        checks++;
        if (halt !== 1'b0) begin failures++; $display("FAIL halt_retoggle: got %b expected 0", halt); end
        for (int i = 0; i < DEB; i++) tick(9'h000);
    endtask

    task automatic test_exam_handshake();
        for (int i = 0; i < DEB - 1; i++) tick(9'h010);
        key_raw = 9'h010; scan_tick = 1'b1; step(); scan_tick = 1'b0;
        checks++;
        if ({cmd_valid, busy} !== 2'b00) begin failures++; $display("FAIL exam_deb_cycle: got %b expected 00", {cmd_valid, busy}); end
        step();
        checks++;
        if (cmd_valid !== 1'b0) begin failures++; $display("FAIL exam_pend_cycle: got %b expected 0", cmd_valid); end
        for (int c = 1; c <= 3; c++) begin
            step();
            checks++;
            if ({cmd_valid, busy, cmd} !== {2'b11, 6'b010000}) begin
                failures++;
                $display("FAIL exam_issue_c%0d: got %b expected 11010000", c, {cmd_valid, busy, cmd});
            end
        end
        cmd_ack = 1'b1; step(); cmd_ack = 1'b0;
        checks++;
        if ({cmd_valid, busy, cmd} !== {2'b01, 6'b000000}) begin
            failures++;
            $display("FAIL exam_after_ack: got %b expected 01000000", {cmd_valid, busy, cmd});
        end
        for (int i = 0; i < DEB - 1; i++) begin
            tick(9'h000);
            checks++;
            if (busy !== 1'b1) begin failures++; $display("FAIL exam_busy_held: got %b expected 1", busy); end
        end
        key_raw = 9'h000; scan_tick = 1'b1; step(); scan_tick = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL exam_busy_deb: got %b expected 1", busy); end
        step();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL exam_busy_clear: got %b expected 0", busy); end
    endtask

    task automatic test_priority();
        int   start;
        logic ok;
        start = vrise;
        for (int i = 0; i < DEB; i++) tick(9'h00C);
        wait_valid(8, ok);
        checks++;
        if (!ok || cmd !== 6'b000100) begin failures++; $display("FAIL prio_first: got %b ok=%b expected 000100", cmd, ok); end
        repeat ($urandom_range(0, 3)) begin
            step();
            checks++;
            if ({cmd_valid, cmd} !== 7'b1000100) begin failures++; $display("FAIL prio_stable: got %b expected 1000100", {cmd_valid, cmd}); end
        end
        cmd_ack = 1'b1; step(); cmd_ack = 1'b0;
        for (int i = 0; i < DEB; i++) tick(9'h008);
        wait_valid(8, ok);
        checks++;
        if (!ok || cmd !== 6'b001000) begin failures++; $display("FAIL prio_second: got %b ok=%b expected 001000", cmd, ok); end
        cmd_ack = 1'b1; step(); cmd_ack = 1'b0;
        for (int i = 0; i < DEB; i++) tick(9'h000);
        repeat (20) step();
        checks++;
        if (vrise - start !== 2) begin failures++; $display("FAIL prio_count: got %0d expected 2", vrise - start); end
    endtask

    task automatic test_timeout();
        int   vc;
        int   ec;
        int   errat;
        int   start;
        logic ok;
        vc = 0; ec = 0; errat = 0;
        for (int i = 0; i < DEB; i++) tick(9'h020);
        wait_valid(8, ok);
        checks++;
        if (!ok || cmd !== 6'b100000) begin failures++; $display("FAIL timeout_issue: got %b ok=%b expected 100000", cmd, ok); end
        for (int i = 0; i < 15; i++) begin
            if (cmd_valid) vc++;
            if (cmd_err) begin ec++; errat = vc; end
            step();
        end
        checks++;
        if (vc !== TO + 1) begin failures++; $display("FAIL timeout_valid_len: got %0d expected %0d", vc, TO + 1); end
        checks++;
        if (ec !== 1 || errat !== TO + 1) begin
            failures++;
            $display("FAIL timeout_err: got pulses=%0d at=%0d expected 1 at %0d", ec, errat, TO + 1);
        end
        start = vrise;
        for (int i = 0; i < 2 * DEB; i++) tick(9'h020);
        checks++;
        if (vrise !== start || busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_no_reissue: got rises=%0d busy=%b expected 0 and 1", vrise - start, busy);
        end
        for (int i = 0; i < DEB; i++) tick(9'h000);
        for (int i = 0; i < DEB; i++) tick(9'h020);
        wait_valid(8, ok);
        checks++;
        if (!ok || cmd !== 6'b100000) begin failures++; $display("FAIL timeout_repress: got %b ok=%b expected 100000", cmd, ok); end
        cmd_ack = 1'b1; step(); cmd_ack = 1'b0;
        for (int i = 0; i < DEB; i++) tick(9'h000);
        step();
    endtask

    task automatic test_cpu_run();
        int start;
        start   = vrise;
        cpu_run = 1'b1;
        for (int i = 0; i < DEB; i++) tick(9'h101);
        step();
        checks++;
        if ({sw, cmd_valid} !== 2'b10) begin failures++; $display("FAIL cpu_run_sw: got %b expected 10", {sw, cmd_valid}); end
        cpu_run = 1'b0;
        repeat (10) step();
        checks++;
        if (vrise !== start || busy !== 1'b0) begin
            failures++;
            $display("FAIL cpu_run_dropped: got rises=%0d busy=%b expected 0 and 0", vrise - start, busy);
        end
        for (int i = 0; i < DEB; i++) tick(9'h000);
    endtask

    task automatic test_reset_mid_issue();
        int   start;
        logic ok;
        for (int i = 0; i < DEB; i++) tick(9'h00C);
        wait_valid(8, ok);
        checks++;
        if (!ok || cmd !== 6'b000100) begin failures++; $display("FAIL rst_pre_issue: got %b ok=%b expected 000100", cmd, ok); end
        reset = 1'b1; step(); reset = 1'b0;
        checks++;
        if ({single_step, halt, sw, cmd, cmd_valid, cmd_err, busy} !== 12'd0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got %b expected 0",
                     {single_step, halt, sw, cmd, cmd_valid, cmd_err, busy});
        end
        start = vrise;
        repeat (10) step();
        for (int i = 0; i < DEB; i++) tick(9'h000);
        checks++;
        if (vrise !== start || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_lost_pend: got rises=%0d busy=%b expected 0 and 0", vrise - start, busy);
        end
    endtask

    task automatic test_random_toggle();
        logic [8:0] raw;
        logic [8:0] m_deb;
        int         m_cnt [9];
        logic [2:0] m_tog;
        logic [2:0] m_pend;
        logic       st;
        int         bit_i;
        reset = 1'b1; key_raw = '0; scan_tick = 1'b0;
        step(); reset = 1'b0; step();
        raw = '0; m_deb = '0; m_tog = '0; m_pend = '0;
        for (int i = 0; i < 9; i++) m_cnt[i] = 0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 11) == 0) begin
                bit_i = 6 + int'($urandom_range(0, 2));
                raw[bit_i] = ~raw[bit_i];
            end
            st        = ($urandom_range(0, 1) == 1);
            key_raw   = raw;
            scan_tick = st;
            // Toggle effect of a debounced press lands one edge after it.
            m_tog  = m_tog ^ m_pend;
            m_pend = '0;
            if (st) begin
                for (int k = 6; k < 9; k++) begin
                    if (raw[k] != m_deb[k]) begin
                        m_cnt[k]++;
                        if (m_cnt[k] == DEB) begin
                            m_deb[k] = raw[k];
                            m_cnt[k] = 0;
                            if (raw[k]) m_pend[k-6] = 1'b1;
                        end
                    end else begin
                        m_cnt[k] = 0;
                    end
                end
            end
            step();
            checks++;
            if ({sw, halt, single_step} !== m_tog) begin
                failures++;
                $display("FAIL rand_toggle[%0d]: got %b expected %b", n, {sw, halt, single_step}, m_tog);
            end
        end
        scan_tick = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rand_no_cmd: got valid=%b busy=%b expected 0 0", cmd_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_debounce_toggle();
        test_exam_handshake();
        test_priority();
        test_timeout();
        test_cpu_run();
        test_reset_mid_issue();
        test_random_toggle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
